// File: rtl/vmx_result_drain_pkg.sv
// Shared vmx package: product width derivation, counter width helper and the
// drain FSM state encoding. Reused by the PE array wrappers and the drain.
package vmx_result_drain_pkg;

    // Drain FSM states: IDLE while the FIFO is empty, SEND while a beat is offered.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

    // A product lane holds the full-precision product of two operands.
    function automatic int product_bitlen(input int vectors_bitlen);
        return 2 * vectors_bitlen;
    endfunction

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmx_result_drain_if.sv
// Result-drain bus: the capture side (ena/product/prod_valid) and the
// AXI-Stream style output side (m_tdata/m_tvalid/m_tready/m_tlast).
//
// Handshake: a beat transfers on a rising clk edge where m_tvalid and
// m_tready are both 1. While m_tvalid=1 and m_tready=0, m_tdata and m_tlast
// stay constant. m_tvalid never depends on m_tready. A result vector is
// captured on an edge where ena=1 and prod_valid=1; there is no back-pressure
// on the capture side -- a vector that finds no room is dropped.
interface vmx_result_drain_if
    import vmx_result_drain_pkg::*;
#(
    parameter int ARRAY_SIZE     = 4,
    parameter int VECTORS_BITLEN = 16
) ();

    localparam int PRODUCT_BITLEN = product_bitlen(VECTORS_BITLEN);

    logic                                 ena;
    logic [PRODUCT_BITLEN*ARRAY_SIZE-1:0] product;
    logic                                 prod_valid;
    logic [PRODUCT_BITLEN-1:0]            m_tdata;
    logic                                 m_tvalid;
    logic                                 m_tready;
    logic                                 m_tlast;

    // Producer/consumer side: drives capture inputs and m_tready.
    modport master (
        output ena, product, prod_valid, m_tready,
        input  m_tdata, m_tvalid, m_tlast
    );

    // Drain side: receives vectors and drives the output stream.
    modport slave (
        input  ena, product, prod_valid, m_tready,
        output m_tdata, m_tvalid, m_tlast
    );

endinterface

// File: rtl/vmx_result_drain_vec_fifo.sv
// vmx_vec_fifo: storage for whole result vectors. Pointers carry one extra
// bit so full (same slot, different lap) and empty (identical) are distinct.
// The head vector is read combinationally.
module vmx_vec_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Vector storage; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/vmx_result_drain.sv
// vmx_result_drain: buffers PE-array result vectors and serialises them one
// product lane per beat onto a stream, with m_tlast every FRAME_LEN vectors.
// A vector arriving with no room is dropped and flagged in sticky overflow.
// Optional build macro VMX_DRAIN_SAT_EN: clamp each lane to the signed
// VECTORS_BITLEN range and sign-extend it onto m_tdata.
module vmx_result_drain
    import vmx_result_drain_pkg::*;
#(
    parameter int ARRAY_SIZE     = 4,
    parameter int VECTORS_BITLEN = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int FRAME_LEN      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    vmx_result_drain_if.slave             bus,
    input  logic                          clr_ovf,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output drain_state_t                  state_dbg
);

    localparam int PB      = product_bitlen(VECTORS_BITLEN);
    localparam int VW      = PB * ARRAY_SIZE;
    localparam int LANE_W  = cnt_width(ARRAY_SIZE);
    localparam int FRAME_W = cnt_width(FRAME_LEN);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

    drain_state_t        state;
    drain_state_t        state_nxt;
    logic [LANE_W-1:0]   lane_cnt;
    logic [FRAME_W-1:0]  frame_cnt;
    logic [VW-1:0]       head;
    logic                full;
    logic                tvalid;
    logic                fire;
    logic                last_lane;
    logic                pop;
    logic                push_req;
    logic                push;
    logic                drop;
    logic [PB-1:0]       lane_raw;
    logic [PB-1:0]       lane_out;

    assign push_req  = bus.ena & bus.prod_valid;
    assign fire      = tvalid & bus.m_tready;
    assign last_lane = (lane_cnt == LANE_W'(ARRAY_SIZE - 1));
    assign pop       = fire & last_lane;
    // A full FIFO still takes the vector when the head leaves on the same edge.
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    vmx_vec_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.product),
        .rdata (head),
        .full  (full),
        .level (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and m_tvalid; SEND exactly while the FIFO holds a vector.
    always_comb begin
        state_nxt = state;
        tvalid    = 1'b0;
        case (state)
            IDLE: begin
                if (push) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tvalid = 1'b1;
                if (pop && !push && fifo_level == LVL_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lane and frame counters; both move only on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt  <= '0;
            frame_cnt <= '0;
        end else if (fire) begin
            if (last_lane) begin
                lane_cnt <= '0;
                if (frame_cnt == FRAME_W'(FRAME_LEN - 1)) begin
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end else begin
                lane_cnt <= lane_cnt + LANE_W'(1);
            end
        end
    end

    // Select the current lane of the head vector.
    always_comb begin
        lane_raw = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                lane_raw = head[k*PB +: PB];
            end
        end
    end

`ifdef VMX_DRAIN_SAT_EN
    localparam logic [PB-1:0] SAT_MAX = {{(PB-VECTORS_BITLEN+1){1'b0}}, {(VECTORS_BITLEN-1){1'b1}}};
    localparam logic [PB-1:0] SAT_MIN = {{(PB-VECTORS_BITLEN+1){1'b1}}, {(VECTORS_BITLEN-1){1'b0}}};

    logic [PB-VECTORS_BITLEN:0] sign_bits;
    assign sign_bits = lane_raw[PB-1:VECTORS_BITLEN-1];

    // Clamp: the lane fits when every bit above the narrow sign bit matches it.
    always_comb begin
        lane_out = lane_raw;
        if (!((&sign_bits) || !(|sign_bits))) begin
            lane_out = lane_raw[PB-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign lane_out = lane_raw;
`endif

    // Sticky overflow; clearing wins over a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign bus.m_tvalid = tvalid;
    assign bus.m_tdata  = tvalid ? lane_out : '0;
    assign bus.m_tlast  = tvalid & last_lane & (frame_cnt == FRAME_W'(FRAME_LEN - 1));
    assign state_dbg    = state;

endmodule

// File: tb/tb_vmx_result_drain.sv
// Bench for vmx_result_drain: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference of the drain behaviour.
module tb_vmx_result_drain;
    import vmx_result_drain_pkg::*;

    localparam int AS    = 4;
    localparam int VB    = 16;
    localparam int PB    = 2 * VB;
    localparam int VW    = PB * AS;
    localparam int DEPTH = 8;
    localparam int FL    = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_ovf;
    logic overflow;
    logic [LVL_W-1:0] fifo_level;
    drain_state_t state_dbg;

    always #5 clk = ~clk;

    vmx_result_drain_if #(.ARRAY_SIZE(AS), .VECTORS_BITLEN(VB)) bus ();

    vmx_result_drain #(
        .ARRAY_SIZE     (AS),
        .VECTORS_BITLEN (VB),
        .FIFO_DEPTH     (DEPTH),
        .FRAME_LEN      (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_ovf    (clr_ovf),
        .overflow   (overflow),
        .fifo_level (fifo_level),
        .state_dbg  (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [VW-1:0] exp_q[$];
    int            m_lane;
    int            m_frame;
    logic          m_ovf;
    logic          exp_valid;
    logic          exp_last;
    logic [PB-1:0] exp_data;
    int            exp_level;

    function automatic logic [PB-1:0] ref_lane(input logic [PB-1:0] x);
`ifdef VMX_DRAIN_SAT_EN
        longint v;
        longint hi;
        longint lo;
        v  = longint'($signed(x));
        hi = (longint'(1) << (VB - 1)) - 1;
        lo = -(longint'(1) << (VB - 1));
        if (v > hi) return PB'(hi);
        if (v < lo) return PB'(lo);
        return x;
`else
        return x;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [VW-1:0] h;
        bit fire;
        bit pop;
        bit req;
        if (rst) begin
            exp_q.delete();
            m_lane  = 0;
            m_frame = 0;
            m_ovf   = 1'b0;
        end else begin
            fire = (exp_q.size() > 0) && bus.m_tready;
            pop  = fire && (m_lane == AS - 1);
            req  = bus.ena && bus.prod_valid;
            if (fire) begin
                if (pop) begin
                    void'(exp_q.pop_front());
                    m_lane  = 0;
                    m_frame = (m_frame + 1) % FL;
                end else begin
                    m_lane++;
                end
            end
            if (req) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(bus.product);
                else m_ovf = 1'b1;
            end
            if (clr_ovf) m_ovf = 1'b0;
        end
        exp_valid = exp_q.size() > 0;
        exp_level = exp_q.size();
        h         = exp_valid ? exp_q[0] : '0;
        exp_data  = exp_valid ? ref_lane(h[m_lane*PB +: PB]) : '0;
        exp_last  = exp_valid && (m_lane == AS - 1) && (m_frame == FL - 1);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ena        = 1'b0;
        bus.prod_valid = 1'b0;
        bus.product    = '0;
        bus.m_tready   = 1'b0;
        clr_ovf        = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < AS; k++) v[k*PB +: PB] = $urandom;
        return v;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0 || bus.m_tlast !== 1'b0 ||
            fifo_level !== '0 || overflow !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_assert got v=%b d=%h l=%b lvl=%0d o=%b want all zero",
                     bus.m_tvalid, bus.m_tdata, bus.m_tlast, fifo_level, overflow);
        end
        cyc();
        rst = 1'b0;
        cyc();
        total++;
        if (bus.m_tvalid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got v=%b lvl=%0d o=%b want 0/0/0",
                     bus.m_tvalid, fifo_level, overflow);
        end
    endtask

    task automatic test_single();
        logic [VW-1:0] v;
        v = {PB'(4), PB'(3), PB'(2), PB'(1)};
        bus.ena = 1'b1; bus.prod_valid = 1'b1; bus.product = v; bus.m_tready = 1'b1;
        cyc();
        bus.prod_valid = 1'b0;
        for (int k = 0; k < AS; k++) begin
            total++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== PB'(k + 1) || bus.m_tlast !== 1'b0 ||
                bus.m_tdata !== exp_data) begin
                bad++;
                $display("FAIL single beat=%0d got v=%b d=%h l=%b want v=1 d=%0d l=0",
                         k, bus.m_tvalid, bus.m_tdata, bus.m_tlast, k + 1);
            end
            cyc();
        end
        total++;
        if (bus.m_tvalid !== 1'b0 || fifo_level !== '0) begin
            bad++;
            $display("FAIL single_empty got v=%b lvl=%0d want 0/0", bus.m_tvalid, fifo_level);
        end
    endtask

    task automatic test_frame();
        int beat = 0;
        int last_cnt = 0;
        int last_beat = 0;
        pulse_reset();
        bus.ena = 1'b1; bus.m_tready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.prod_valid = (c < 5);
            bus.product    = rand_vec();
            cyc();
            total++;
            if (bus.m_tvalid !== exp_valid || bus.m_tdata !== exp_data || bus.m_tlast !== exp_last ||
                fifo_level !== LVL_W'(exp_level) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL frame c=%0d got v=%b d=%h l=%b lvl=%0d o=%b want v=%b d=%h l=%b lvl=%0d o=%b",
                         c, bus.m_tvalid, bus.m_tdata, bus.m_tlast, fifo_level, overflow,
                         exp_valid, exp_data, exp_last, exp_level, m_ovf);
            end
            if (bus.m_tvalid && bus.m_tready) begin
                beat++;
                if (bus.m_tlast) begin
                    last_cnt++;
                    last_beat = beat;
                end
            end
        end
        total++;
        if (beat != 20 || last_cnt != 1 || last_beat != 16) begin
            bad++;
            $display("FAIL frame_tlast got beats=%0d lasts=%0d at=%0d want 20/1/16",
                     beat, last_cnt, last_beat);
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        idle_inputs();
        bus.ena = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.prod_valid = (c < 9);
            bus.product    = rand_vec();
            cyc();
            total++;
            if (bus.m_tvalid !== exp_valid || bus.m_tdata !== exp_data || bus.m_tlast !== exp_last ||
                fifo_level !== LVL_W'(exp_level) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL ovf_fill c=%0d got v=%b d=%h l=%b lvl=%0d o=%b want v=%b d=%h l=%b lvl=%0d o=%b",
                         c, bus.m_tvalid, bus.m_tdata, bus.m_tlast, fifo_level, overflow,
                         exp_valid, exp_data, exp_last, exp_level, m_ovf);
            end
        end
        total++;
        if (fifo_level !== LVL_W'(DEPTH) || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full got lvl=%0d o=%b want %0d/1", fifo_level, overflow, DEPTH);
        end
        bus.prod_valid = 1'b0;
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0 || fifo_level !== LVL_W'(DEPTH)) begin
            bad++;
            $display("FAIL ovf_clear got o=%b lvl=%0d want 0/%0d", overflow, fifo_level, DEPTH);
        end
    endtask

    // Runs with the FIFO left full by test_overflow.
    task automatic test_full_pop();
        int beats = 0;
        bus.m_tready = 1'b1;
        for (int c = 0; c < 3; c++) cyc();
        bus.prod_valid = 1'b1;
        bus.product    = rand_vec();
        cyc();
        bus.prod_valid = 1'b0;
        total++;
        if (fifo_level !== LVL_W'(DEPTH) || overflow !== 1'b0 || exp_level != DEPTH) begin
            bad++;
            $display("FAIL full_pop got lvl=%0d o=%b want %0d/0", fifo_level, overflow, DEPTH);
        end
        for (int c = 0; c < 40; c++) begin
            total++;
            if (bus.m_tvalid !== exp_valid || bus.m_tdata !== exp_data || bus.m_tlast !== exp_last ||
                fifo_level !== LVL_W'(exp_level) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL full_drain c=%0d got v=%b d=%h l=%b lvl=%0d o=%b want v=%b d=%h l=%b lvl=%0d o=%b",
                         c, bus.m_tvalid, bus.m_tdata, bus.m_tlast, fifo_level, overflow,
                         exp_valid, exp_data, exp_last, exp_level, m_ovf);
            end
            if (bus.m_tvalid) beats++;
            cyc();
        end
        total++;
        if (beats != DEPTH * AS) begin
            bad++;
            $display("FAIL full_drain_beats got %0d want %0d", beats, DEPTH * AS);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] v;
        int beat = 0;
        int last_beat = 0;
        idle_inputs();
        bus.ena = 1'b1; bus.prod_valid = 1'b1; bus.product = rand_vec(); bus.m_tready = 1'b1;
        cyc();
        bus.prod_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        total++;
        if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0 || bus.m_tlast !== 1'b0 ||
            fifo_level !== '0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got v=%b d=%h l=%b lvl=%0d o=%b want all zero",
                     bus.m_tvalid, bus.m_tdata, bus.m_tlast, fifo_level, overflow);
        end
        cyc();
        rst = 1'b0;
        v = rand_vec();
        for (int c = 0; c < 22; c++) begin
            bus.prod_valid = (c < 4);
            bus.product    = (c == 0) ? v : rand_vec();
            cyc();
            if (c == 0) begin
                total++;
                if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== ref_lane(v[PB-1:0])) begin
                    bad++;
                    $display("FAIL mid_first got v=%b d=%h want 1/%h", bus.m_tvalid, bus.m_tdata,
                             ref_lane(v[PB-1:0]));
                end
            end
            total++;
            if (bus.m_tvalid !== exp_valid || bus.m_tdata !== exp_data || bus.m_tlast !== exp_last ||
                fifo_level !== LVL_W'(exp_level) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL mid_run c=%0d got v=%b d=%h l=%b lvl=%0d o=%b want v=%b d=%h l=%b lvl=%0d o=%b",
                         c, bus.m_tvalid, bus.m_tdata, bus.m_tlast, fifo_level, overflow,
                         exp_valid, exp_data, exp_last, exp_level, m_ovf);
            end
            if (bus.m_tvalid) begin
                beat++;
                if (bus.m_tlast) last_beat = beat;
            end
        end
        total++;
        if (last_beat != 16) begin
            bad++;
            $display("FAIL mid_tlast got beat=%0d want 16", last_beat);
        end
        idle_inputs();
    endtask

    task automatic test_sat();
        logic [PB-1:0] want [AS];
        idle_inputs();
`ifdef VMX_DRAIN_SAT_EN
        want[0] = 32'h0000_7FFF; want[1] = 32'hFFFF_8000;
`else
        want[0] = 32'h0001_2345; want[1] = 32'hFFFF_0000;
`endif
        want[2] = 32'h0000_7FFF; want[3] = 32'hFFFF_8000;
        bus.ena = 1'b1; bus.prod_valid = 1'b1; bus.m_tready = 1'b1;
        bus.product = {32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFF_0000, 32'h0001_2345};
        cyc();
        bus.prod_valid = 1'b0;
        for (int k = 0; k < AS; k++) begin
            total++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== want[k]) begin
                bad++;
                $display("FAIL sat lane=%0d got v=%b d=%h want 1/%h", k, bus.m_tvalid, bus.m_tdata, want[k]);
            end
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 800; c++) begin
            bus.ena        = ($urandom_range(0, 9) != 0);
            bus.prod_valid = ($urandom_range(0, 2) == 0);
            bus.product    = rand_vec();
            bus.m_tready   = ($urandom_range(0, 3) != 0) || (c >= 760);
            clr_ovf        = ($urandom_range(0, 30) == 0);
            if (c >= 760) bus.prod_valid = 1'b0;
            if (c >= 200 && c < 260) bus.m_tready = 1'b0;
            cyc();
            total++;
            if (bus.m_tvalid !== exp_valid || bus.m_tdata !== exp_data || bus.m_tlast !== exp_last ||
                fifo_level !== LVL_W'(exp_level) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL random c=%0d got v=%b d=%h l=%b lvl=%0d o=%b want v=%b d=%h l=%b lvl=%0d o=%b",
                         c, bus.m_tvalid, bus.m_tdata, bus.m_tlast, fifo_level, overflow,
                         exp_valid, exp_data, exp_last, exp_level, m_ovf);
            end
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_frame();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vmx_result_drain.md
VMX_RESULT_DRAIN -- requirements
Module: vmx_result_drain

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 4: number of product lanes per result vector.
REQ-002 SHALL have parameter VECTORS_BITLEN, default 16: operand width; product lane width is PRODUCT_BITLEN = 2*VECTORS_BITLEN.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: result vectors buffered; power of two, at least 2.
REQ-004 SHALL have parameter FRAME_LEN, default 4: result vectors per output frame (m_tlast period).
REQ-005 SHALL have port clk  input  1: single clock, rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port ena  input  1: capture enable, same meaning as the PE array ena.
REQ-008 SHALL have port product  input  PRODUCT_BITLEN*ARRAY_SIZE: result vector; lane k = bits [k*PRODUCT_BITLEN +: PRODUCT_BITLEN].
REQ-009 SHALL have port prod_valid  input  1: product holds a valid result vector this cycle.
REQ-010 SHALL have port m_tdata  output  PRODUCT_BITLEN: one product lane per beat.
REQ-011 SHALL have port m_tvalid  output  1: beat valid.
REQ-012 SHALL have port m_tready  input  1: downstream accepts beat.
REQ-013 SHALL have port m_tlast  output  1: last beat of a frame.
REQ-014 SHALL have port clr_ovf  input  1: synchronous clear of overflow.
REQ-015 SHALL have port overflow  output  1: sticky, a vector was dropped.
REQ-016 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1: stored vectors, including the one being sent.

Function
REQ-017 SHALL push product into the FIFO on a clock edge where ena=1, prod_valid=1 and the FIFO is not full (after counting a same-cycle pop).
REQ-018 SHALL, when full, no pop completes and a push is requested, drop the vector and set overflow the next cycle.
REQ-019 SHALL accept a push on a full FIFO when the final beat of the head vector is accepted in that same cycle; level stays unchanged.
REQ-020 SHALL use FSM states IDLE (FIFO empty, m_tvalid=0) and SEND (m_tvalid=1); IDLE->SEND on a push; SEND->IDLE when the last lane is accepted and the FIFO becomes empty.
REQ-021 SHALL assert m_tvalid on the cycle after the first push into an empty FIFO, a one-cycle latency.
REQ-022 SHALL emit lanes of the head vector in order 0..ARRAY_SIZE-1, advancing the lane counter only on m_tvalid & m_tready.
REQ-023 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL pop the head vector when lane ARRAY_SIZE-1 is accepted, then reset the lane counter to 0.
REQ-025 SHALL count sent vectors modulo FRAME_LEN and assert m_tlast on lane ARRAY_SIZE-1 of vector FRAME_LEN-1 of each frame.
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH, using an extra pointer bit to tell full from empty.
REQ-027 SHALL give clr_ovf priority over a same-cycle drop, so overflow reads 0 next cycle.
REQ-028 SHALL ignore prod_valid while ena=0; draining continues regardless of ena.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-frame, force state IDLE, pointers, lane and frame counters to 0, and m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, fifo_level=0.
REQ-030 SHALL discard a partially sent vector on reset; the first beat after reset is lane 0 and starts a new frame.

Configuration
REQ-031 SHALL, with VMX_DRAIN_SAT_EN defined, clamp each lane to the signed VECTORS_BITLEN range and sign-extend it to PRODUCT_BITLEN on m_tdata; without the macro, lanes pass unmodified.

Structure
REQ-032 SHALL take the PRODUCT_BITLEN derivation and the FSM state encodings from the shared vmx package, reused by the PE array wrappers.
REQ-033 SHALL put FIFO storage and pointers in one sub-module, vmx_vec_fifo; the FSM, serializer and frame counter stay at top level.

Verification
REQ-034 SHALL cover: one vector {4,3,2,1} (lane0=1), m_tready=1 -> beats 1,2,3,4 on consecutive cycles starting one cycle after capture, m_tlast=0.
REQ-035 SHALL cover: 4 vectors, m_tready=1 -> 16 beats, m_tlast high only on beat 16; a 5th vector restarts the frame.
REQ-036 SHALL cover: m_tready=0, 9 vectors pushed (depth 8) -> fifo_level=8, overflow=1, the 9th vector never appears; clr_ovf -> overflow=0.
REQ-037 SHALL cover: full FIFO, lane 3 accepted in the same cycle as a new push -> push accepted, level stays 8, no overflow.
REQ-038 SHALL cover: rst pulsed after lane 1 of a vector -> all outputs 0 within the reset cycle; the next pushed vector starts at lane 0, frame count 0.
REQ-039 SHALL cover, with VMX_DRAIN_SAT_EN: lane 0x00012345 -> 0x00007FFF; lane 0xFFFF0000 -> 0xFFFF8000; without the macro, both pass unchanged.
